// File: rtl/fsm_sym_sequencer_pkg.sv
// Shared sizes and state encoding for the symbol sequencer and its program store.
package fsm_sym_sequencer_pkg;

   localparam int unsigned SEQ_DEPTH = 8;
   localparam int unsigned SEQ_SYM_W = 2;
   localparam int unsigned SEQ_IDX_W = 3;
   localparam int unsigned SEQ_LEN_W = SEQ_IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sym_store.sv
// Program storage: DEPTH entries of {symbol, expected}, one write port, one combinational read port.
module sym_store
   import fsm_sym_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = SEQ_DEPTH,
   parameter int unsigned SYM_W = SEQ_SYM_W
) (
   input  logic                 Clk,
   input  logic                 wr_en,
   input  logic [SEQ_IDX_W-1:0] wr_addr,
   input  logic [2*SYM_W-1:0]   wr_data,
   input  logic [SEQ_IDX_W-1:0] rd_addr,
   output logic [2*SYM_W-1:0]   rd_data_c
);

   logic [2*SYM_W-1:0] mem [DEPTH];

   // No reset: the program survives a sequencer reset.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/fsm_sym_sequencer.sv
// Plays a stored symbol program into a Moore FSM and scores its outputs one cycle later.
module fsm_sym_sequencer
   import fsm_sym_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = SEQ_DEPTH,
   parameter int unsigned SYM_W = SEQ_SYM_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 WrEn,
   input  logic [SEQ_IDX_W-1:0] WrAddr,
   input  logic [SYM_W-1:0]     WrSym,
   input  logic [SYM_W-1:0]     WrExp,
   input  logic                 Start,
   input  logic [SEQ_LEN_W-1:0] Len,
   input  logic                 Abort,
   output logic [SYM_W-1:0]     SymOut,
   output logic                 SymValid,
   input  logic [SYM_W-1:0]     DutOut,
   output logic                 Busy,
   output logic                 Done,
   output logic [3:0]           ErrCount,
   output logic [SEQ_IDX_W-1:0] FirstErrIdx
);

   seq_state_t           state;
   logic [SEQ_LEN_W-1:0] len_q;
   logic [SEQ_LEN_W-1:0] cnt;
   logic [SYM_W-1:0]     exp_out;
   logic [SYM_W-1:0]     exp_chk;
   logic [SEQ_IDX_W-1:0] idx_out;
   logic [SEQ_IDX_W-1:0] idx_chk;
   logic                 chk_valid;
   logic [2*SYM_W-1:0]   rd_entry;
   logic [SYM_W-1:0]     rd_sym;
   logic [SYM_W-1:0]     rd_exp;
   logic [SEQ_LEN_W-1:0] len_clamped;
   logic                 mismatch;
   logic                 store_we;

   assign {rd_sym, rd_exp} = rd_entry;
   assign len_clamped      = (Len > SEQ_LEN_W'(DEPTH)) ? SEQ_LEN_W'(DEPTH) : Len;
   assign mismatch         = chk_valid && (DutOut != exp_chk);
   assign store_we         = WrEn && (state == ST_IDLE);

   // Read address is the issue count, which rests at 0 in IDLE so Start sees entry 0.
   sym_store #(
      .DEPTH (DEPTH),
      .SYM_W (SYM_W)
   ) u_sym_store (
      .Clk       (Clk),
      .wr_en     (store_we),
      .wr_addr   (WrAddr),
      .wr_data   ({WrSym, WrExp}),
      .rd_addr   (cnt[SEQ_IDX_W-1:0]),
      .rd_data_c (rd_entry)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_IDLE;
         len_q       <= '0;
         cnt         <= '0;
         SymOut      <= '0;
         SymValid    <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         ErrCount    <= '0;
         FirstErrIdx <= '0;
         exp_out     <= '0;
         exp_chk     <= '0;
         idx_out     <= '0;
         idx_chk     <= '0;
         chk_valid   <= 1'b0;
      end else begin
         Done      <= 1'b0;
         // DutOut trails SymOut by one cycle, so the expectation is delayed to match.
         chk_valid <= SymValid;
         exp_chk   <= exp_out;
         idx_chk   <= idx_out;

         if ((state == ST_RUN || state == ST_DRAIN) && !Abort && mismatch) begin
            if (ErrCount == '0) begin
               FirstErrIdx <= idx_chk;
            end
            ErrCount <= ErrCount + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (Start) begin
                  len_q       <= len_clamped;
                  ErrCount    <= '0;
                  FirstErrIdx <= '0;
                  Busy        <= 1'b1;
                  if (len_clamped == '0) begin
                     state <= ST_FIN;
                     Done  <= 1'b1;
                  end else begin
                     state    <= ST_RUN;
                     SymOut   <= rd_sym;
                     SymValid <= 1'b1;
                     exp_out  <= rd_exp;
                     idx_out  <= '0;
                     cnt      <= SEQ_LEN_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (Abort) begin
                  state    <= ST_IDLE;
                  SymOut   <= '0;
                  SymValid <= 1'b0;
                  Busy     <= 1'b0;
                  cnt      <= '0;
               end else if (cnt == len_q) begin
                  state    <= ST_DRAIN;
                  SymOut   <= '0;
                  SymValid <= 1'b0;
               end else begin
                  SymOut  <= rd_sym;
                  exp_out <= rd_exp;
                  idx_out <= cnt[SEQ_IDX_W-1:0];
                  cnt     <= cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (Abort) begin
                  state <= ST_IDLE;
                  Busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  state <= ST_FIN;
                  Done  <= 1'b1;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fsm_sym_sequencer.md
FSM_SYM_SEQUENCER -- requirements
Module: fsm_sym_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, number of program entries.
REQ-002 Parameter SYM_W, default 2, symbol and output width.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 WrEn  input  1  program-entry write strobe.
REQ-006 WrAddr  input  3  entry index, 0..7.
REQ-007 WrSym  input  SYM_W  symbol to store.
REQ-008 WrExp  input  SYM_W  expected FSM output for that symbol.
REQ-009 Start  input  1  single-cycle run request.
REQ-010 Len  input  4  entries to play, sampled with Start.
REQ-011 Abort  input  1  cancel the active run.
REQ-012 SymOut  output  SYM_W  symbol driven to the controlled Moore FSM input.
REQ-013 SymValid  output  1  SymOut is valid this cycle.
REQ-014 DutOut  input  SYM_W  controlled FSM output, registered one cycle behind SymOut.
REQ-015 Busy  output  1  run in progress.
REQ-016 Done  output  1  single-cycle completion pulse.
REQ-017 ErrCount  output  4  mismatches in the last run.
REQ-018 FirstErrIdx  output  3  index of the first mismatch; valid when ErrCount is non-zero.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN and FIN, encoded as 2 bits.
REQ-020 In IDLE, WrEn SHALL write {WrSym, WrExp} to entry WrAddr at the clock edge; WrEn outside IDLE SHALL be ignored.
REQ-021 In IDLE, Start SHALL:
- latch Len, with Len above 8 clamped to 8;
- clear ErrCount and FirstErrIdx;
- set the index to 0;
- enter RUN, or enter FIN directly if the latched Len is 0.
REQ-022 In RUN, each cycle SHALL drive SymOut equal to the entry symbol at the index with SymValid high, then increment the index; after index Len-1 is issued, the next state SHALL be DRAIN.
REQ-023 In the cycle after each SymValid-high cycle, DutOut SHALL be compared with the expected value of the issued index; on inequality, ErrCount SHALL increment, and FirstErrIdx SHALL capture that index if ErrCount was 0.
REQ-024 DRAIN SHALL last one cycle with SymValid low, perform the final comparison, then enter FIN.
REQ-025 FIN SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-026 Busy SHALL be high in RUN, DRAIN and FIN, and low in IDLE.
REQ-027 Start while Busy is high SHALL be ignored; Start and WrEn in the same IDLE cycle SHALL perform both, and the run SHALL use the old entry value only if its write targets entry 0 (the write lands at the same edge the index is set).
REQ-028 Abort in RUN or DRAIN SHALL enter IDLE at the next edge:
- SymValid low from that edge;
- no Done pulse;
- no further comparisons;
- ErrCount holds its partial value.
REQ-029 Abort has priority over Start; Abort in IDLE or FIN SHALL have no effect.
REQ-030 SymOut SHALL be 0 whenever SymValid is low.
REQ-031 Latency from Start to the first SymValid SHALL be 1 cycle; from Start to Done, Len+2 cycles (Len 0: 1 cycle).

Reset
REQ-032 Reset SHALL force IDLE, with SymOut=0, SymValid=0, Busy=0, Done=0, ErrCount=0, FirstErrIdx=0 and the index 0.
REQ-033 Reset SHALL NOT clear program entries.
REQ-034 Reset mid-run SHALL abandon the run with no Done pulse.

Structure
REQ-035 A shared package SHALL hold the state encoding, DEPTH, SYM_W and the index width.
REQ-036 Program storage SHALL be a sub-module, sym_store: DEPTH x 2*SYM_W registers, one write port, one combinational read port.

Verification
REQ-037 Program symbols 3,0,1,3 with expected 1,1,0,3; Start with Len=4 and DutOut matching -> SymOut 3,0,1,3 on cycles 1-4, Done at cycle 6, ErrCount=0.
REQ-038 Same program, DutOut wrong for index 2 only -> ErrCount=1, FirstErrIdx=2.
REQ-039 Len=0 -> no SymValid, Done at cycle 1, ErrCount=0; Len=12 -> 8 symbols issued, Done at cycle 10.
REQ-040 Abort at the 2nd RUN cycle of a Len=6 run -> Busy low next cycle, no Done, 2 symbols issued.
REQ-041 Start and WrEn pulsed while Busy -> both ignored; program and run unchanged.
REQ-042 Reset at the 3rd RUN cycle -> all outputs at reset values next cycle; a new run replays the unchanged program.
